// File: rtl/irq_controller.sv
// Priority interrupt controller: edge-captures request lines into a pending
// register, gates them with a per-line mask, raises one interrupt to the CPU,
// vectors the highest-index eligible line on acknowledge, and then holds an
// in-service state until end-of-interrupt.
//
// Ports:
//   clk        single clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   irq        level request lines, synchronous to clk (bit k = line k+1)
//   mask_we    mask write strobe
//   mask_in    new mask value (1 = line masked)
//   inta       CPU acknowledge pulse
//   eoi        CPU end-of-interrupt pulse
//   intr       interrupt request to the CPU
//   vec        vector of the acknowledged line (0 = none/spurious)
//   vec_valid  one-cycle strobe qualifying vec
//   pending    pending register
//   mask       current mask register
//   in_service a line is being serviced
module irq_controller #(
    parameter int unsigned NIRQ = 3,
    parameter int unsigned VW   = $clog2(NIRQ + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NIRQ-1:0] irq,
    input  logic            mask_we,
    input  logic [NIRQ-1:0] mask_in,
    input  logic            inta,
    input  logic            eoi,
    output logic            intr,
    output logic [VW-1:0]   vec,
    output logic            vec_valid,
    output logic [NIRQ-1:0] pending,
    output logic [NIRQ-1:0] mask,
    output logic            in_service
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [NIRQ-1:0] prev;
    logic [NIRQ-1:0] rise;
    logic [NIRQ-1:0] elig;
    logic [VW-1:0]   top_idx;
    logic [NIRQ-1:0] top_bit;
    logic [NIRQ-1:0] pend_clr;
    logic [NIRQ-1:0] pending_n;
    logic [NIRQ-1:0] mask_n;
    logic            intr_n;
    logic [VW-1:0]   vec_n;
    logic            vec_valid_n;
    logic            in_service_n;

    // Rising-edge detect against the previous sample, and mask gating.
    assign rise = irq & ~prev;
    assign elig = pending & ~mask;

    // Highest-index eligible line; later iterations overwrite lower ones.
    always_comb begin
        top_idx = '0;
        top_bit = '0;
        for (int unsigned i = 0; i < NIRQ; i++) begin
            if (elig[i]) begin
                top_idx    = VW'(i + 1);
                top_bit    = '0;
                top_bit[i] = 1'b1;
            end
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_n      = state;
        intr_n       = 1'b0;
        vec_n        = vec;
        vec_valid_n  = 1'b0;
        in_service_n = in_service;
        pend_clr     = '0;

        case (state)
            IDLE: begin
                in_service_n = 1'b0;
                if (|elig) begin
                    state_n = REQ;
                    intr_n  = 1'b1;
                end
            end
            REQ: begin
                if (inta) begin
                    // top_idx is 0 when everything got masked: spurious vector.
                    vec_n       = top_idx;
                    vec_valid_n = 1'b1;
                    if (|elig) begin
                        pend_clr     = top_bit;
                        in_service_n = 1'b1;
                        state_n      = SERVICE;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (|elig) begin
                    intr_n = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            SERVICE: begin
                in_service_n = 1'b1;
                if (eoi) begin
                    in_service_n = 1'b0;
                    state_n      = IDLE;
                end
            end
            default: begin
                state_n      = IDLE;
                in_service_n = 1'b0;
            end
        endcase

        // A new edge on a line being acknowledged keeps it pending.
        pending_n = (pending & ~pend_clr) | rise;
        mask_n    = mask_we ? mask_in : mask;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            prev       <= '0;
            pending    <= '0;
            mask       <= '0;
            intr       <= 1'b0;
            vec        <= '0;
            vec_valid  <= 1'b0;
            in_service <= 1'b0;
        end else begin
            state      <= state_n;
            prev       <= irq;
            pending    <= pending_n;
            mask       <= mask_n;
            intr       <= intr_n;
            vec        <= vec_n;
            vec_valid  <= vec_valid_n;
            in_service <= in_service_n;
        end
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Sequencing controller for the priority-encoded interrupt lines.
- Captures rising edges on NIRQ request lines into a pending register and applies a per-line mask.
- Raises one interrupt to the CPU, resolves the highest-index eligible line on acknowledge and returns its number as a vector.
- Holds an in-service state until the CPU signals end-of-interrupt. Sits between peripheral IRQ lines and the CPU interrupt pins.

Parameters:
- NIRQ, 3: number of request lines. Line i is IRQ[i-1], with i = 1..NIRQ.
- VW, $clog2(NIRQ+1): vector width. Vector 0 means none/spurious.

Ports:
- CLK  input  1  single clock; all state changes on the rising edge.
- RST_N  input  1  synchronous, active-low reset.
- IRQ  input  NIRQ  level request lines, already synchronous to CLK. Bit k is line k+1.
- MASK_WE  input  1  mask write strobe.
- MASK_IN  input  NIRQ  new mask value; 1 = line masked.
- INTA  input  1  CPU acknowledge, 1-cycle pulse.
- EOI  input  1  CPU end-of-interrupt, 1-cycle pulse.
- INT  output  1  interrupt request to CPU.
- VEC  output  VW  vector of the acknowledged line.
- VEC_VALID  output  1  1-cycle strobe qualifying VEC.
- PENDING  output  NIRQ  pending register, for visibility.
- MASK  output  NIRQ  current mask register.
- IN_SERVICE  output  1  a line is being serviced.

Behaviour:
- Reset is synchronous and active-low: RST_N sampled 0 at a CLK edge resets all state, regardless of FSM state.
- Reset values: prev-IRQ register = 0, PENDING = 0, MASK = 0 (all enabled), FSM = IDLE, INT = 0, VEC = 0, VEC_VALID = 0, IN_SERVICE = 0.
- Consequence of prev = 0 at reset: a line already high when reset is released counts as an edge on the first active cycle.
- Edge detect: at each edge, edge = IRQ & ~prev; then prev <= IRQ. An edge sets its PENDING bit at that same clock edge.
- Edges only: a level held high does not re-pend, and a second edge on an already-pending bit has no effect (no counting).
- Masked lines still latch PENDING. Mask only gates eligibility: elig = PENDING & ~MASK.
- MASK <= MASK_IN at any edge with MASK_WE = 1, in any state. It takes effect on elig in the following cycle.
- Priority: the highest index wins. IRQ3 beats IRQ2, which beats IRQ1.
- FSM states: IDLE, REQ, SERVICE. All outputs are registered.
- IDLE:
  - INT = 0.
  - If elig != 0 at an edge -> REQ, with INT = 1 from that edge.
  - Latency: an IRQ edge sampled at edge k sets PENDING after k; INT is high after k+1.
- REQ, INT = 1:
  - INTA = 1 with elig != 0: VEC <= index of the highest elig bit, VEC_VALID = 1 for exactly one cycle. That PENDING bit clears, IN_SERVICE <= 1, INT <= 0, -> SERVICE.
  - INTA = 1 with elig = 0 (masked meanwhile): VEC <= 0, VEC_VALID = 1 (spurious), INT <= 0, -> IDLE. IN_SERVICE stays 0.
  - No INTA and elig = 0: INT <= 0, -> IDLE.
  - No INTA and elig != 0: stay in REQ.
  - Priority is resolved at the INTA cycle, not at INT assertion. A higher line arriving while in REQ is the one vectored.
- SERVICE:
  - INT = 0, IN_SERVICE = 1. No nesting: new edges latch into PENDING but raise no INT.
  - EOI = 1 -> IN_SERVICE <= 0, -> IDLE. If elig != 0, INT rises one edge later via IDLE.
- Ignored inputs: INTA outside REQ; EOI outside SERVICE.
- Simultaneous set/clear: an edge on the same line being cleared by INTA in the same cycle leaves the bit set (set wins).
- VEC holds its last value between strobes. Only VEC_VALID qualifies it.

Test Plan:
1. Reset, then pulse IRQ[0] (line 1), then INTA when INT = 1 -> INT high 2 edges after the IRQ edge; VEC = 1 with VEC_VALID for 1 cycle; PENDING = 000; IN_SERVICE = 1. Then EOI -> IN_SERVICE = 0, FSM IDLE, INT = 0.
2. IRQ = 3'b111 rising together, then INTA/EOI repeated three times -> vectors 3, 2, 1 in order; PENDING 011, 001, 000 after each INTA.
3. MASK = 3'b100, IRQ rises on 100 -> PENDING = 100 and INT stays 0. Then write MASK = 000 -> INT rises; INTA gives VEC = 3.
4. Line 1 pended with INT = 1 in REQ; write MASK = 001, then INTA -> VEC = 0 (spurious) with VEC_VALID = 1, IN_SERVICE = 0, PENDING = 001 kept.
5. In SERVICE for line 2, IRQ3 edge -> no INT. EOI -> INT = 1 next cycle; INTA gives VEC = 3. Also hold IRQ1 high for 10 cycles -> pends only once.
6. Drive RST_N = 0 for 1 cycle while in REQ with PENDING = 110 -> next cycle all outputs at reset values. IRQ lines still high -> re-pend on the first cycle after reset.
